// File: rtl/call_return_ctrl_if.sv
// CALL/RET handshake and return-stack bus for call_return_ctrl.
// master: decode + stack side; slave: the controller.
interface call_return_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
);
  logic              call_req;
  logic              ret_req;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] call_target;
  logic              err_clr;
  logic              call_ack;
  logic              ret_ack;
  logic              busy;
  logic              pc_load;
  logic [DATA_W-1:0] pc_next;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_din;
  logic [DATA_W-1:0] stk_dout;
  logic              stk_empty;
  logic              stk_full;
  logic [CNT_W-1:0]  depth;
  logic              overflow_err;
  logic              underflow_err;
  logic              mismatch_err;

  modport master (
    output call_req, ret_req, pc_plus4, call_target, err_clr,
    output stk_dout, stk_empty, stk_full,
    input  call_ack, ret_ack, busy, pc_load, pc_next,
    input  stk_push, stk_pop, stk_din, depth,
    input  overflow_err, underflow_err, mismatch_err
  );

  modport slave (
    input  call_req, ret_req, pc_plus4, call_target, err_clr,
    input  stk_dout, stk_empty, stk_full,
    output call_ack, ret_ack, busy, pc_load, pc_next,
    output stk_push, stk_pop, stk_din, depth,
    output overflow_err, underflow_err, mismatch_err
  );
endinterface

// File: rtl/call_return_ctrl.sv
// CALL/RET controller for the return-address stack: push/pop strobes,
// PC redirect, depth tracking, sticky over/underflow and flag-mismatch errors.
// Ports: clk, rst_n (async, active low), bus (call_return_ctrl_if.slave).
module call_return_ctrl #(
  parameter int DATA_W        = 32,
  parameter int STACK_DEPTH   = 15,
  parameter int CNT_W         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  call_return_ctrl_if.slave  bus
);

  localparam int WCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(STACK_DEPTH);
  localparam logic [WCNT_W-1:0] WLOAD = WCNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE
  } state_e;

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [CNT_W-1:0]    depth_q;
  logic                call_ack_q;
  logic                ret_ack_q;
  logic                busy_q;
  logic                pc_load_q;
  logic [DATA_W-1:0]   pc_next_q;
  logic                push_q;
  logic                pop_q;
  logic [DATA_W-1:0]   din_q;
  logic                ovf_q;
  logic                unf_q;
  logic                mis_q;

  // During an ack pulse decode still holds the request it is being
  // acked for; ignore it so a rejected request is not served twice.
  logic take;
  logic flag_bad;
  assign take = (state_q == IDLE) && !call_ack_q && !ret_ack_q;
  assign flag_bad = (bus.stk_empty != (depth_q == '0)) ||
                    (bus.stk_full  != (depth_q == FULL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      depth_q    <= '0;
      call_ack_q <= 1'b0;
      ret_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_next_q  <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      din_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      call_ack_q <= 1'b0;
      ret_ack_q  <= 1'b0;
      pc_load_q  <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      // Clear first; a same-cycle error below overrides it.
      if (bus.err_clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        mis_q <= 1'b0;
      end
      if (state_q == IDLE && flag_bad) begin
        mis_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (take && bus.ret_req) begin
            ret_ack_q <= 1'b1;
            if (depth_q == '0) begin
              unf_q <= 1'b1;
            end else begin
              pc_next_q <= bus.stk_dout;
              pc_load_q <= 1'b1;
              pop_q     <= 1'b1;
              depth_q   <= depth_q - CNT_W'(1);
              busy_q    <= 1'b1;
              state_q   <= ISSUE;
            end
          end else if (take && bus.call_req) begin
            call_ack_q <= 1'b1;
            if (depth_q == FULL) begin
              ovf_q <= 1'b1;
            end else begin
              pc_next_q <= bus.call_target;
              din_q     <= bus.pc_plus4;
              pc_load_q <= 1'b1;
              push_q    <= 1'b1;
              depth_q   <= depth_q + CNT_W'(1);
              busy_q    <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wcnt_q  <= WLOAD;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (wcnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.call_ack      = call_ack_q;
  assign bus.ret_ack       = ret_ack_q;
  assign bus.busy          = busy_q;
  assign bus.pc_load       = pc_load_q;
  assign bus.pc_next       = pc_next_q;
  assign bus.stk_push      = push_q;
  assign bus.stk_pop       = pop_q;
  assign bus.stk_din       = din_q;
  assign bus.depth         = depth_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
  assign bus.mismatch_err  = mis_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Self-checking bench for call_return_ctrl with a behavioural
// return stack and a queue-based reference of the CALL/RET rules.
module tb_call_return_ctrl;
  localparam int DW = 32;
  localparam int SD = 15;
  localparam int CW = 4;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  call_return_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus();

  call_return_ctrl #(
    .DATA_W(DW), .STACK_DEPTH(SD), .CNT_W(CW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Behavioural stack: flags registered from the pre-update pointer.
  logic [DW-1:0] phys[$];
  logic [DW-1:0] dout_q;
  logic emp_q, full_q;
  bit flip_full = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phys.delete();
      emp_q  <= 1'b1;
      full_q <= 1'b0;
      dout_q <= '0;
    end else begin
      emp_q  <= (phys.size() == 0);
      full_q <= (phys.size() == SD);
      if (bus.stk_push) phys.push_back(bus.stk_din);
      else if (bus.stk_pop && phys.size() != 0) void'(phys.pop_back());
      dout_q <= (phys.size() != 0) ? phys[$] : '0;
    end
  end

  assign bus.stk_dout  = dout_q;
  assign bus.stk_empty = emp_q;
  assign bus.stk_full  = full_q ^ flip_full;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic          c_ack;
    logic          r_ack;
    logic          push;
    logic          pop;
    logic          pcl;
    logic [DW-1:0] pc_next;
    logic [DW-1:0] din;
    logic [CW-1:0] depth;
    logic          ovf;
    logic          unf;
    logic          mis;
    int            lat;
    int            bc;
  } obs_t;

  // Reference model state
  logic [DW-1:0] ref_q[$];
  bit r_ovf, r_unf, r_mis;

  function automatic obs_t predict(bit is_ret, bit clr,
                                   logic [DW-1:0] pc4, logic [DW-1:0] tgt);
    obs_t e;
    e = '0;
    e.lat = 1;
    if (clr) begin r_ovf = 0; r_unf = 0; r_mis = 0; end
    if (is_ret) begin
      e.r_ack = 1'b1;
      if (ref_q.size() == 0) r_unf = 1;
      else begin
        e.pop = 1'b1; e.pcl = 1'b1;
        e.pc_next = ref_q.pop_back();
        e.bc = 1 + SC;
      end
    end else begin
      e.c_ack = 1'b1;
      if (ref_q.size() == SD) r_ovf = 1;
      else begin
        e.push = 1'b1; e.pcl = 1'b1;
        e.pc_next = tgt; e.din = pc4;
        ref_q.push_back(pc4);
        e.bc = 1 + SC;
      end
    end
    e.depth = CW'(ref_q.size());
    e.ovf = r_ovf; e.unf = r_unf; e.mis = r_mis;
    return e;
  endfunction

  // Drive a request (time phase: just after a rising edge), wait for
  // its ack, snapshot outputs, then count busy cycles.
  task automatic run_req(input bit c, input bit r, input bit clr,
                         input logic [DW-1:0] pc4,
                         input logic [DW-1:0] tgt, output obs_t o);
    bus.call_req = c; bus.ret_req = r; bus.err_clr = clr;
    bus.pc_plus4 = pc4; bus.call_target = tgt;
    o = '0;
    do begin
      @(posedge clk); #1;
      o.lat++;
    end while (!(bus.call_ack || bus.ret_ack) && o.lat < 20);
    bus.err_clr = 1'b0;
    o.c_ack = bus.call_ack; o.r_ack = bus.ret_ack;
    o.push = bus.stk_push; o.pop = bus.stk_pop; o.pcl = bus.pc_load;
    o.pc_next = bus.pc_load ? bus.pc_next : '0;
    o.din = bus.stk_push ? bus.stk_din : '0;
    o.depth = bus.depth;
    o.ovf = bus.overflow_err; o.unf = bus.underflow_err;
    o.mis = bus.mismatch_err;
    if (bus.ret_ack) bus.ret_req = 1'b0;
    else if (bus.call_ack) bus.call_req = 1'b0;
    else begin bus.call_req = 1'b0; bus.ret_req = 1'b0; end
    while (bus.busy && o.bc < 20) begin
      o.bc++;
      @(posedge clk); #1;
    end
    if (o.bc == 0) begin @(posedge clk); #1; end
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    r_ovf = 0; r_unf = 0; r_mis = 0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({bus.call_ack, bus.ret_ack, bus.busy, bus.pc_load,
         bus.stk_push, bus.stk_pop} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000",
        {bus.call_ack, bus.ret_ack, bus.busy, bus.pc_load,
         bus.stk_push, bus.stk_pop});
    end
    n_chk++;
    if ({bus.pc_next, bus.stk_din} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h want 0 0",
        bus.pc_next, bus.stk_din);
    end
    n_chk++;
    if ({bus.depth, bus.overflow_err, bus.underflow_err,
         bus.mismatch_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_depth_err: got %h want 0",
        {bus.depth, bus.overflow_err, bus.underflow_err, bus.mismatch_err});
    end
  endtask

  task automatic test_call();
    obs_t o, e;
    e = predict(0, 0, 32'h104, 32'h200);
    run_req(1, 0, 0, 32'h104, 32'h200, o);
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL call_basic: got %p want %p", o, e);
    end
    n_chk++;
    if (o.pc_next !== 32'h200 || o.din !== 32'h104 || o.depth !== 4'd1) begin
      n_fail++; $display("FAIL call_values: got pc=%h din=%h d=%0d want 200 104 1",
        o.pc_next, o.din, o.depth);
    end
    n_chk++;
    if (o.bc !== 3 || o.lat !== 1) begin
      n_fail++; $display("FAIL call_timing: got busy=%0d lat=%0d want 3 1",
        o.bc, o.lat);
    end
  endtask

  task automatic test_ret();
    obs_t o, e;
    e = predict(1, 0, 0, 0);
    run_req(0, 1, 0, 32'h0, 32'h0, o);
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL ret_basic: got %p want %p", o, e);
    end
    n_chk++;
    if (o.pc_next !== 32'h104 || o.pop !== 1'b1 || o.depth !== 4'd0) begin
      n_fail++; $display("FAIL ret_values: got pc=%h pop=%b d=%0d want 104 1 0",
        o.pc_next, o.pop, o.depth);
    end
  endtask

  task automatic test_underflow();
    obs_t o, e;
    e = predict(1, 0, 0, 0);
    run_req(0, 1, 0, 32'h0, 32'h0, o);
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL underflow: got %p want %p", o, e);
    end
    n_chk++;
    if (o.unf !== 1'b1 || o.pop !== 1'b0 || o.pcl !== 1'b0 || o.bc !== 0) begin
      n_fail++; $display("FAIL underflow_flags: got unf=%b pop=%b pcl=%b bc=%0d want 1 0 0 0",
        o.unf, o.pop, o.pcl, o.bc);
    end
    clear_errs();
    n_chk++;
    if (bus.underflow_err !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clr: got %b want 0", bus.underflow_err);
    end
    // New error in the same cycle as err_clr wins.
    e = predict(1, 1, 0, 0);
    run_req(0, 1, 1, 32'h0, 32'h0, o);
    n_chk++;
    if (o.unf !== 1'b1 || o !== e) begin
      n_fail++; $display("FAIL clr_vs_set: got %p want %p", o, e);
    end
    clear_errs();
  endtask

  task automatic test_overflow_lifo();
    obs_t o, e;
    int bad = 0;
    for (int i = 0; i < SD; i++) begin
      e = predict(0, 0, 32'h1000 + i * 4, 32'h8000 + i);
      run_req(1, 0, 0, 32'h1000 + i * 4, 32'h8000 + i, o);
      if (o !== e) bad++;
    end
    n_chk++;
    if (bad != 0 || bus.depth !== 4'd15) begin
      n_fail++; $display("FAIL nested_calls: got %0d bad, depth=%0d want 0 15",
        bad, bus.depth);
    end
    e = predict(0, 0, 32'hdead, 32'hbeef);
    run_req(1, 0, 0, 32'hdead, 32'hbeef, o);
    n_chk++;
    if (o.ovf !== 1'b1 || o.push !== 1'b0 || o.depth !== 4'd15 || o !== e) begin
      n_fail++; $display("FAIL overflow: got %p want %p", o, e);
    end
    bad = 0;
    for (int i = SD - 1; i >= 0; i--) begin
      e = predict(1, 0, 0, 0);
      run_req(0, 1, 0, 0, 0, o);
      if (o !== e || o.pc_next !== 32'h1000 + i * 4) bad++;
    end
    n_chk++;
    if (bad != 0 || bus.depth !== 4'd0) begin
      n_fail++; $display("FAIL lifo_rets: got %0d bad, depth=%0d want 0 0",
        bad, bus.depth);
    end
    clear_errs();
  endtask

  task automatic test_priority();
    obs_t o, e;
    e = predict(0, 0, 32'h40, 32'h400);
    run_req(1, 0, 0, 32'h40, 32'h400, o);
    e = predict(0, 0, 32'h80, 32'h800);
    run_req(1, 0, 0, 32'h80, 32'h800, o);
    e = predict(1, 0, 0, 0);
    run_req(1, 1, 0, 32'h2c0, 32'h3c0, o);
    n_chk++;
    if (o.r_ack !== 1'b1 || o.c_ack !== 1'b0 || o.pc_next !== 32'h80 || o !== e) begin
      n_fail++; $display("FAIL prio_ret_first: got %p want %p", o, e);
    end
    e = predict(0, 0, 32'h2c0, 32'h3c0);
    run_req(1, 0, 0, 32'h2c0, 32'h3c0, o);
    n_chk++;
    if (o !== e || o.depth !== 4'd2) begin
      n_fail++; $display("FAIL prio_call_after: got %p want %p", o, e);
    end
    e = predict(1, 0, 0, 0);
    run_req(0, 1, 0, 0, 0, o);
    e = predict(1, 0, 0, 0);
    run_req(0, 1, 0, 0, 0, o);
  endtask

  task automatic test_mismatch();
    flip_full = 1'b1;
    @(posedge clk); #1;
    flip_full = 1'b0;
    n_chk++;
    if (bus.mismatch_err !== 1'b1) begin
      n_fail++; $display("FAIL mismatch_set: got %b want 1", bus.mismatch_err);
    end
    clear_errs();
    n_chk++;
    if (bus.mismatch_err !== 1'b0) begin
      n_fail++; $display("FAIL mismatch_clr: got %b want 0", bus.mismatch_err);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int bad = 0;
    logic [DW-1:0] a, t;
    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 9);
      a = $urandom; t = $urandom;
      if (k <= 4) begin
        e = predict(0, 0, a, t);
        run_req(1, 0, 0, a, t, o);
      end else if (k <= 7) begin
        e = predict(1, 0, 0, 0);
        run_req(0, 1, 0, 0, 0, o);
      end else if (k == 8) begin
        e = predict(1, 0, 0, 0);
        run_req(1, 1, 0, a, t, o);
        n_chk++;
        if (o !== e) begin
          bad++; n_fail++;
          $display("FAIL rand_both_ret[%0d]: got %p want %p", n, o, e);
        end
        e = predict(0, 0, a, t);
        run_req(1, 0, 0, a, t, o);
      end else begin
        e = predict(0, 1, a, t);
        run_req(1, 0, 1, a, t, o);
      end
      n_chk++;
      if (o !== e) begin
        bad++; n_fail++;
        $display("FAIL rand_op[%0d]: got %p want %p", n, o, e);
      end
      if (bad > 10) break;
    end
  endtask

  task automatic test_reset_mid();
    bus.call_req = 1'b1; bus.pc_plus4 = 32'h55; bus.call_target = 32'h66;
    @(posedge clk); #1;
    bus.call_req = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_busy: got %b want 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.call_ack, bus.ret_ack, bus.busy, bus.pc_load, bus.stk_push,
         bus.stk_pop, bus.depth, bus.pc_next, bus.stk_din} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outs: got busy=%b d=%0d pc=%h want 0",
        bus.busy, bus.depth, bus.pc_next);
    end
    ref_q.delete(); r_ovf = 0; r_unf = 0; r_mis = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.depth !== 4'd0 || bus.mismatch_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: got busy=%b d=%0d mis=%b want 0 0 0",
        bus.busy, bus.depth, bus.mismatch_err);
    end
  endtask

  initial begin
    bus.call_req = 1'b0; bus.ret_req = 1'b0; bus.err_clr = 1'b0;
    bus.pc_plus4 = '0; bus.call_target = '0;
    r_ovf = 0; r_unf = 0; r_mis = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_call();
    test_ret();
    test_underflow();
    test_overflow_lifo();
    test_priority();
    test_mismatch();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
